// File: rtl/sga_pkg.sv
// Shared Snake Game Arcade definitions: grid geometry, cell codes and the
// render sequencer state encoding.
package sga_pkg;

    localparam int GRID_X     = 16;
    localparam int GRID_Y     = 16;
    localparam int GRID_CELLS = GRID_X * GRID_Y;
    localparam int POS_W      = 8;
    localparam int MAX_SIZE   = 64;
    localparam int SIZE_W     = 7;
    localparam int ADDR_W     = 6;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BODY  = 2'b01;
    localparam logic [1:0] CELL_HEAD  = 2'b10;
    localparam logic [1:0] CELL_APPLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_APPLE = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } render_state_t;

endpackage

// File: rtl/sga_index_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that
// is high while the count equals the supplied terminal value.
module sga_index_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         restart_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/sga_render_ctrl.sv
// Render sequencer: clears the framebuffer, paints the apple, then paints
// every snake segment read from the body RAM (head first).
module sga_render_ctrl #(
    parameter int GRID_CELLS = sga_pkg::GRID_CELLS,
    parameter int POS_W      = sga_pkg::POS_W,
    parameter int MAX_SIZE   = sga_pkg::MAX_SIZE,
    parameter int SIZE_W     = sga_pkg::SIZE_W,
    parameter int ADDR_W     = sga_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              restart_n,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic [POS_W-1:0]  apple_pos,
    output logic [ADDR_W-1:0] body_addr,
    input  logic [POS_W-1:0]  body_data,
    output logic              fb_we,
    output logic [POS_W-1:0]  fb_addr,
    output logic [1:0]        fb_data,
    output logic              busy,
    output logic              render_finish,
    output logic [2:0]        db_state
);

    import sga_pkg::*;

    render_state_t     state;
    logic [SIZE_W-1:0] size_lat;
    logic [POS_W-1:0]  apple_lat;
    logic [SIZE_W-1:0] eff_size;
    logic [SIZE_W-1:0] seg_last;
    logic [POS_W:0]    idx;
    logic [SIZE_W-1:0] seg;
    logic              idx_tc, seg_tc;
    logic              idx_clr, idx_en, seg_clr, seg_en;
    logic              accept;

    // Oversized lengths saturate at the body RAM depth instead of wrapping.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
        if (s > SIZE_W'(MAX_SIZE)) begin
            return SIZE_W'(MAX_SIZE);
        end
        return s;
    endfunction

    assign accept   = (state == ST_IDLE) && start;
    assign eff_size = clamp_size(size_lat);
    assign seg_last = eff_size - SIZE_W'(1);

    // The top idx bit never sets in normal operation; it blocks any overrun.
    assign idx_clr = accept || ((state == ST_CLEAR) && idx_tc);
    assign idx_en  = (state == ST_CLEAR) && !idx[POS_W];
    assign seg_clr = accept;
    assign seg_en  = (state == ST_WRITE);

    sga_index_counter #(.W(POS_W + 1)) u_cell_idx (
        .clock     (clock),
        .restart_n (restart_n),
        .clr       (idx_clr),
        .en        (idx_en),
        .last      ((POS_W + 1)'(GRID_CELLS - 1)),
        .count     (idx),
        .tc        (idx_tc)
    );

    sga_index_counter #(.W(SIZE_W)) u_seg_idx (
        .clock     (clock),
        .restart_n (restart_n),
        .clr       (seg_clr),
        .en        (seg_en),
        .last      (seg_last),
        .count     (seg),
        .tc        (seg_tc)
    );

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state     <= ST_IDLE;
            size_lat  <= '0;
            apple_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CLEAR;
                        size_lat  <= size;
                        apple_lat <= apple_pos;
                    end
                end
                ST_CLEAR: if (idx_tc) state <= ST_APPLE;
                ST_APPLE: state <= (eff_size == '0) ? ST_DONE : ST_READ;
                ST_READ:  state <= ST_WRITE;
                ST_WRITE: state <= seg_tc ? ST_DONE : ST_READ;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode of the registered state; WRITE forwards the RAM read data.
    always_comb begin
        fb_we         = 1'b0;
        fb_addr       = '0;
        fb_data       = CELL_EMPTY;
        body_addr     = '0;
        busy          = (state != ST_IDLE);
        render_finish = 1'b0;
        db_state      = state;
        case (state)
            ST_CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = idx[POS_W-1:0];
            end
            ST_APPLE: begin
                fb_we   = 1'b1;
                fb_addr = apple_lat;
                fb_data = CELL_APPLE;
            end
            ST_READ: begin
                body_addr = seg[ADDR_W-1:0];
            end
            ST_WRITE: begin
                body_addr = seg[ADDR_W-1:0];
                fb_we     = 1'b1;
                fb_addr   = body_data;
                fb_data   = (seg == '0) ? CELL_HEAD : CELL_BODY;
            end
            ST_DONE: render_finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sga_render_ctrl.sv
// Directed bench for sga_render_ctrl with a synchronous body RAM model.
module tb_sga_render_ctrl;

    logic       clock = 1'b0;
    logic       restart_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] size = '0;
    logic [7:0] apple_pos = '0;
    logic [5:0] body_addr;
    logic [7:0] body_data = '0;
    logic       fb_we;
    logic [7:0] fb_addr;
    logic [1:0] fb_data;
    logic       busy;
    logic       render_finish;
    logic [2:0] db_state;

    logic [7:0] ram [64];
    logic [9:0] wr_q [$];
    logic [9:0] exp_q [$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         fin_cyc, n_reads, rd_max, n_fin;
    logic       busy_after;

    sga_render_ctrl dut (
        .clock         (clock),
        .restart_n     (restart_n),
        .start         (start),
        .size          (size),
        .apple_pos     (apple_pos),
        .body_addr     (body_addr),
        .body_data     (body_data),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .busy          (busy),
        .render_finish (render_finish),
        .db_state      (db_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) body_data <= ram[body_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Pulses start, records every framebuffer write until render_finish.
    // disturb=1 toggles start and changes size/apple while the render runs.
    task automatic run_render(input logic [6:0] sz, input logic [7:0] ap, input bit disturb);
        wr_q.delete();
        n_reads = 0;
        rd_max = 0;
        fin_cyc = -1;
        @(negedge clock);
        size = sz;
        apple_pos = ap;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clock);
            if (fb_we) wr_q.push_back({fb_addr, fb_data});
            if (db_state == 3'd3) begin
                n_reads++;
                if (int'(body_addr) > rd_max) rd_max = int'(body_addr);
            end
            if (render_finish) begin
                fin_cyc = c;
                break;
            end
            start = 1'b0;
            if (disturb && (c == 50 || c == 259)) begin
                start = 1'b1;
                size = 7'd50;
                apple_pos = 8'h77;
            end
        end
        start = 1'b0;
        @(negedge clock);
        busy_after = busy;
    endtask

    task automatic build_expected(input int sz, input logic [7:0] ap);
        int s;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 2'b00});
        exp_q.push_back({ap, 2'b11});
        s = (sz > 64) ? 64 : sz;
        for (int k = 0; k < s; k++) exp_q.push_back({ram[k], (k == 0) ? 2'b10 : 2'b01});
    endtask

    task automatic compare_writes(input string tag);
        int errs = 0;
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) errs++;
        check({tag, "_seq_errs"}, errs, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'(i * 3 + 7);
        repeat (3) @(posedge clock);
        #1;
        check("rst_outs", {fb_we, fb_addr, fb_data, body_addr, busy, render_finish, db_state}, 0);
        @(negedge clock) restart_n = 1'b1;
        @(negedge clock);
        check("idle_state", db_state, 3'd0);

        // Reset during CLEAR
        @(negedge clock);
        size = 7'd3;
        apple_pos = 8'h25;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        check("pre_rst_state", db_state, 3'd1);
        check("pre_rst_idx", fb_addr, 8'd100);
        #2 restart_n = 1'b0;
        #1;
        check("mid_rst_outs", {fb_we, fb_addr, fb_data, body_addr, busy, render_finish, db_state}, 0);
        repeat (2) @(negedge clock);
        restart_n = 1'b1;
        n_fin = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (render_finish || busy) n_fin++;
        end
        check("post_rst_quiet", n_fin, 0);

        // Normal render, size 3
        ram[0] = 8'h44; ram[1] = 8'h43; ram[2] = 8'h42;
        run_render(7'd3, 8'h25, 1'b0);
        build_expected(3, 8'h25);
        compare_writes("s3");
        check("s3_apple", wr_q[256], {8'h25, 2'b11});
        check("s3_head", wr_q[257], {8'h44, 2'b10});
        check("s3_body1", wr_q[258], {8'h43, 2'b01});
        check("s3_body2", wr_q[259], {8'h42, 2'b01});
        check("s3_latency", fin_cyc, 264);
        check("s3_busy_after", busy_after, 1'b0);

        // Disturbed run must match the undisturbed one
        run_render(7'd3, 8'h25, 1'b1);
        compare_writes("dist");
        check("dist_latency", fin_cyc, 264);

        // Size 0
        run_render(7'd0, 8'hFF, 1'b0);
        build_expected(0, 8'hFF);
        compare_writes("s0");
        check("s0_last", wr_q[256], {8'hFF, 2'b11});
        check("s0_latency", fin_cyc, 258);
        check("s0_reads", n_reads, 0);

        // Oversized length clamps at 64
        for (int i = 0; i < 64; i++) ram[i] = 8'(i * 3 + 7);
        run_render(7'd100, 8'h01, 1'b0);
        build_expected(100, 8'h01);
        compare_writes("s100");
        check("s100_latency", fin_cyc, 1 + 256 + 1 + 128);
        check("s100_reads", n_reads, 64);
        check("s100_rdmax", rd_max, 63);

        // Segment on the apple cell
        ram[0] = 8'h11; ram[1] = 8'h10; ram[2] = 8'h12;
        run_render(7'd3, 8'h10, 1'b0);
        begin
            logic [1:0] last_code = 2'b00;
            foreach (wr_q[i]) if (wr_q[i][9:2] == 8'h10) last_code = wr_q[i][1:0];
            check("collide_code", last_code, 2'b01);
        end
        check("collide_latency", fin_cyc, 264);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
